i2s_transmitter: RTL

- Serialises signed NCO output samples onto an I2S link (Philips format) toward the external DAC.
- Sits directly downstream of nco, clocked by master_clk, and paced by clk_div enables: sample_clk_en and bit_clk_en.
- Mono source: the same sample is sent on the left and right slots.
- Owns i2s_bclk, i2s_ws and i2s_sd at the top level.

---
 rtl/synth_pkg.sv | 15 +
 rtl/i2s_sample_holder.sv | 43 ++++
 rtl/i2s_transmitter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synthesiser audio path.
// The I2S transmitter and its sample holder import this package.
package synth_pkg;

    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int SLOT_WIDTH_DEF   = 16;

    typedef logic signed [SAMPLE_WIDTH_DEF-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

endpackage

// File: rtl/i2s_sample_holder.sv
// Holds the most recent NCO sample until the transmitter loads a frame.
// A capture that coincides with a load is forwarded straight into that load.
module i2s_sample_holder
    import synth_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
    input  logic                           master_clk,
    input  logic                           rst,
    input  logic                           sample_clk_en,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           load,
    output logic signed [SAMPLE_WIDTH-1:0] load_sample,
    output logic                           load_fresh
);

    logic signed [SAMPLE_WIDTH-1:0] hold_q;
    logic                           fresh_q;
    logic                           capture;

    assign capture     = sample_clk_en && sample_valid;
    assign load_sample = capture ? sample_in : hold_q;
    assign load_fresh  = fresh_q || capture;

    // A load always consumes the sample, including one bypassed in this cycle.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            if (capture) begin
                hold_q <= sample_in;
            end
            if (load) begin
                fresh_q <= 1'b0;
            end else if (capture) begin
                fresh_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips-format I2S serialiser: sends each mono sample in both slots, MSB first,
// with BCLK, WS and SD all registered off the clk_div strobes.
module i2s_transmitter
    import synth_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF
) (
    input  logic                           master_clk,
    input  logic                           rst,
    input  logic                           sample_clk_en,
    input  logic                           bit_clk_en,
    input  logic                           enable,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                           sample_valid,
    output logic                           i2s_bclk,
    output logic                           i2s_ws,
    output logic                           i2s_sd,
    output logic                           frame_start,
    output logic                           underrun
);

    localparam int FRAME_W = 2 * SLOT_WIDTH;
    localparam int PW      = $clog2(FRAME_W);
    localparam logic [PW-1:0] P_LAST    = PW'(FRAME_W - 1);
    localparam logic [PW-1:0] P_WS_FIRST = PW'(SLOT_WIDTH - 1);

    if (SLOT_WIDTH < SAMPLE_WIDTH) begin : g_bad_slot
        $error("i2s_transmitter: SLOT_WIDTH must be >= SAMPLE_WIDTH");
    end

    i2s_state_e                     state_q, state_d;
    logic [PW-1:0]                  p_q, p_d;
    logic [FRAME_W-1:0]             shreg_q, shreg_d;
    logic                           bclk_d, ws_d, sd_d, fs_d, ur_d;
    logic                           load;
    logic signed [SAMPLE_WIDTH-1:0] load_sample;
    logic                           load_fresh;
    logic [SLOT_WIDTH-1:0]          slot;
    logic [FRAME_W-1:0]             frame_word;

    i2s_sample_holder #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_holder (
        .master_clk    (master_clk),
        .rst           (rst),
        .sample_clk_en (sample_clk_en),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .load          (load),
        .load_sample   (load_sample),
        .load_fresh    (load_fresh)
    );

    always_comb begin
        slot = '0;
        slot[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = load_sample;
        frame_word = {slot, slot};
    end

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            shreg_q     <= '0;
            i2s_bclk    <= 1'b0;
            i2s_ws      <= 1'b0;
            i2s_sd      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            shreg_q     <= shreg_d;
            i2s_bclk    <= bclk_d;
            i2s_ws      <= ws_d;
            i2s_sd      <= sd_d;
            frame_start <= fs_d;
            underrun    <= ur_d;
        end
    end

    // Data only moves on BCLK falling transitions so the DAC samples it stable on the rise.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        shreg_d = shreg_q;
        bclk_d  = i2s_bclk;
        ws_d    = i2s_ws;
        sd_d    = i2s_sd;
        fs_d    = 1'b0;
        ur_d    = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bit_clk_en && enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                    p_d     = '0;
                    shreg_d = frame_word;
                    sd_d    = frame_word[FRAME_W-1];
                    ws_d    = 1'b0;
                    bclk_d  = 1'b0;
                    fs_d    = 1'b1;
                    ur_d    = !load_fresh;
                end
            end
            RUN: begin
                if (bit_clk_en) begin
                    if (!i2s_bclk) begin
                        bclk_d = 1'b1;
                    end else begin
                        bclk_d = 1'b0;
                        if (p_q == P_LAST) begin
                            p_d  = '0;
                            ws_d = 1'b0;
                            if (enable) begin
                                load    = 1'b1;
                                shreg_d = frame_word;
                                sd_d    = frame_word[FRAME_W-1];
                                fs_d    = 1'b1;
                                ur_d    = !load_fresh;
                            end else begin
                                state_d = IDLE;
                                shreg_d = '0;
                                sd_d    = 1'b0;
                            end
                        end else begin
                            p_d     = p_q + 1'b1;
                            shreg_d = shreg_q << 1;
                            sd_d    = shreg_q[FRAME_W-2];
                            ws_d    = (p_d >= P_WS_FIRST) && (p_d != P_LAST);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
